mem_arbiter: RTL

- Sequences the single-port backing data memory and shares it between two requesters: instruction-side (I) and data-side / cache (D).
- Grants one requester at a time and drives the backing memory request.
- Waits for the memory acknowledge, or a timeout, then returns a one-cycle acknowledge and read data to the granted requester.
- Sits between the fetch/cache miss paths and the backing memory inside the core's top level.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_timeout_counter.sv | 38 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for mem_arbiter and its timeout counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
    typedef enum logic       {REQ_I, REQ_D}               req_id_t;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT);

    // Counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice (TIMEOUT >= 2).
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Wait-cycle counter for one backing-memory transaction; expired_o flags the
// last cycle (count == TIMEOUT-1) on which a mem_ack is still accepted.
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I/D) arbiter in front of a single-port backing memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              busy, expired, done, pick_d;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);
    // Ack wins over a same-cycle timeout.
    assign done = busy && (mem_ack || expired);

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!busy),
        .en_i      (busy),
        .expired_o (expired)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t ptr_q, ptr_d;

    assign pick_d = d_req && (!i_req || (ptr_q == REQ_D));

    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = (state_q == BUSY_D) ? REQ_I : REQ_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= REQ_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // NOTE: every next-state signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !mem_ack;
                        d_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !mem_ack;
                        i_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule
